// File: rtl/ioctl_ram_upload.sv
// Upload (save) reader for the cartridge RAM window: answers hps_io read strobes
// with RAM bytes while holding the console off the RAM. Optional macro: IOCTL_UPLOAD_DIRTY_EN.
module ioctl_ram_upload #(
  parameter logic [15:0] BASE_ADDR    = 16'h7000,
  parameter logic [15:0] LAST_ADDR    = 16'hFFFF,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd1,
  parameter logic [23:0] REQ_TIMEOUT  = 24'd5000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        save_req,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic        ioctl_upload_req,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_q,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [2:0]  dbg_state
`ifdef IOCTL_UPLOAD_DIRTY_EN
  ,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  output logic        dirty
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQUEST = 3'd1;
  localparam logic [2:0] ACTIVE  = 3'd2;
  localparam logic [2:0] FETCH   = 3'd3;
  localparam logic [2:0] LATCH   = 3'd4;

  localparam logic [15:0] LAST_OFS16 = LAST_ADDR - BASE_ADDR;
  localparam logic [24:0] LAST_OFS   = {9'd0, LAST_OFS16};

  // Handshake: hps_io pulses ioctl_rd for one cycle; ioctl_wait is high from that
  // same cycle until ioctl_din holds the requested byte, and ioctl_addr is held
  // stable for the whole time ioctl_wait is high.

  logic [2:0]  state;
  logic [23:0] req_cnt;
  logic        out_of_window;
  logic        end_pend;
  logic        start_ok;
  logic        upload_ok;
  logic        rd_take;
  logic        finish;

`ifdef IOCTL_UPLOAD_DIRTY_EN
  logic cpu_in_window;
  assign cpu_in_window = cpu_we && (cpu_addr >= BASE_ADDR) && (cpu_addr <= LAST_ADDR);
  assign start_ok      = save_req && dirty;
`else
  assign start_ok      = save_req;
`endif

  assign upload_ok = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign rd_take   = (state == ACTIVE) && ioctl_upload && ioctl_rd;
  // An upload-fall seen during FETCH is remembered so the read still completes.
  assign finish    = ((state == ACTIVE) && !ioctl_upload) ||
                     ((state == LATCH) && (end_pend || !ioctl_upload));

  assign ioctl_wait = rd_take || (state == FETCH) || (state == LATCH);
  assign cpu_hold   = (state == ACTIVE) || (state == FETCH) || (state == LATCH);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= IDLE;
      req_cnt          <= 24'd0;
      ioctl_upload_req <= 1'b0;
      ioctl_din        <= 8'h00;
      mem_addr         <= BASE_ADDR;
      done             <= 1'b0;
      timeout_err      <= 1'b0;
      out_of_window    <= 1'b0;
      end_pend         <= 1'b0;
    end else begin
      ioctl_upload_req <= 1'b0;
      done             <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            ioctl_upload_req <= 1'b1;
            timeout_err      <= 1'b0;
            req_cnt          <= REQ_TIMEOUT;
            end_pend         <= 1'b0;
            state            <= REQUEST;
          end
        end
        REQUEST: begin
          if (upload_ok) begin
            state <= ACTIVE;
          end else if (req_cnt <= 24'd1) begin
            req_cnt     <= 24'd0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            req_cnt <= req_cnt - 24'd1;
          end
        end
        ACTIVE: begin
          if (finish) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (rd_take) begin
            mem_addr      <= BASE_ADDR + ioctl_addr[15:0];
            out_of_window <= (ioctl_addr > LAST_OFS);
            end_pend      <= 1'b0;
            state         <= FETCH;
          end
        end
        FETCH: begin
          if (!ioctl_upload) end_pend <= 1'b1;
          state <= LATCH;
        end
        LATCH: begin
          ioctl_din <= out_of_window ? 8'hFF : mem_q;
          if (finish) begin
            done     <= 1'b1;
            end_pend <= 1'b0;
            state    <= IDLE;
          end else begin
            state <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IOCTL_UPLOAD_DIRTY_EN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty <= 1'b0;
    end else if (cpu_in_window) begin
      dirty <= 1'b1;
    end else if (finish) begin
      dirty <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ioctl_ram_upload.sv
// Directed bench for ioctl_ram_upload: request timeout, table-driven reads,
// upload-fall and reset corner cases, dirty gating when IOCTL_UPLOAD_DIRTY_EN is set.
module tb_ioctl_ram_upload;

  localparam logic [23:0] T = 24'd40;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_req;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic        ioctl_upload_req;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_q;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [2:0]  dbg_state;
`ifdef IOCTL_UPLOAD_DIRTY_EN
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic        dirty;
`endif

  logic [7:0] ram [0:65535];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  exp_din;
    logic [15:0] exp_maddr;
  } rd_vec_t;

  rd_vec_t vecs [6];

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= ram[mem_addr];

  ioctl_ram_upload #(.REQ_TIMEOUT(T)) dut (
    .clk_sys          (clk),
    .reset            (reset),
    .save_req         (save_req),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_rd         (ioctl_rd),
    .ioctl_addr       (ioctl_addr),
    .ioctl_upload_req (ioctl_upload_req),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .mem_addr         (mem_addr),
    .mem_q            (mem_q),
    .cpu_hold         (cpu_hold),
    .busy             (busy),
    .done             (done),
    .timeout_err      (timeout_err),
    .dbg_state        (dbg_state)
`ifdef IOCTL_UPLOAD_DIRTY_EN
    ,
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .dirty            (dirty)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic request();
`ifdef IOCTL_UPLOAD_DIRTY_EN
    @(negedge clk); cpu_we = 1'b1; cpu_addr = 16'hFFFF;
    @(negedge clk); cpu_we = 1'b0;
`else
    @(negedge clk);
`endif
    save_req = 1'b1;
    @(negedge clk); save_req = 1'b0;
  endtask

  task automatic activate();
    request();
    ioctl_index = 8'd1; ioctl_upload = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] ed, input logic [15:0] em, input int idx);
    @(negedge clk); ioctl_rd = 1'b1; ioctl_addr = a;
    #1 check($sformatf("wait_rd[%0d]", idx), ioctl_wait, 1);
    @(negedge clk); ioctl_rd = 1'b0;
    check($sformatf("wait_fetch[%0d]", idx), ioctl_wait, 1);
    check($sformatf("mem_addr[%0d]", idx), mem_addr, em);
    @(negedge clk);
    check($sformatf("wait_latch[%0d]", idx), ioctl_wait, 1);
    @(negedge clk);
    check($sformatf("wait_drop[%0d]", idx), ioctl_wait, 0);
    check($sformatf("din[%0d]", idx), ioctl_din, ed);
  endtask

  initial begin
    int cycles;
    logic saw_hold;

    vecs[0] = '{25'h0000000, 8'h5A, 16'h7000};
    vecs[1] = '{25'h0008FFF, 8'hC3, 16'hFFFF};
    vecs[2] = '{25'h0009000, 8'hFF, 16'h0000};
    vecs[3] = '{25'h0001000, 8'h77, 16'h8000};
    vecs[4] = '{25'h1FFFFFF, 8'hFF, 16'h6FFF};
    vecs[5] = '{25'h0010000, 8'hFF, 16'h7000};

    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[16'h7000] = 8'h5A;
    ram[16'hFFFF] = 8'hC3;
    ram[16'h8000] = 8'h77;
    ram[16'h0000] = 8'h11;

    reset = 1'b1; save_req = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0;
`ifdef IOCTL_UPLOAD_DIRTY_EN
    cpu_we = 1'b0; cpu_addr = 16'h0000;
`endif
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_din", ioctl_din, 8'h00);
    check("rst_maddr", mem_addr, 16'h7000);
    check("rst_outs", {ioctl_upload_req, ioctl_wait, cpu_hold, busy, done, timeout_err}, 0);
    reset = 1'b0;

    // request with no upload answer: exact timeout length, RAM never taken
    request();
    check("req_pulse", ioctl_upload_req, 1);
    check("req_busy", busy, 1);
    cycles = 0; saw_hold = 1'b0;
    while (busy && cycles < T + 10) begin
      @(negedge clk);
      cycles++;
      if (cpu_hold) saw_hold = 1'b1;
      if (cycles == 1) check("req_pulse_end", ioctl_upload_req, 0);
    end
    check("timeout_cycles", cycles, T);
    check("timeout_err", timeout_err, 1);
    check("timeout_state", dbg_state, 0);
    check("timeout_no_hold", saw_hold, 0);

    // new request clears timeout_err; wrong index is ignored
    request();
    check("terr_cleared", timeout_err, 0);
    ioctl_index = 8'd2; ioctl_upload = 1'b1;
    repeat (3) @(negedge clk);
    check("wrong_idx_state", dbg_state, 1);
    check("wrong_idx_hold", cpu_hold, 0);
    ioctl_index = 8'd1;
    @(negedge clk);
    check("active_state", dbg_state, 2);
    check("active_hold", cpu_hold, 1);

    for (int i = 0; i < 6; i++) do_read(vecs[i].addr, vecs[i].exp_din, vecs[i].exp_maddr, i);

    // save_req while active must not re-request
    @(negedge clk); save_req = 1'b1;
    @(negedge clk); save_req = 1'b0;
    check("dup_req_0", ioctl_upload_req, 0);
    @(negedge clk);
    check("dup_req_1", ioctl_upload_req, 0);
    check("dup_req_state", dbg_state, 2);

    // upload falls the cycle after rd: read completes, then done
    @(negedge clk); ioctl_rd = 1'b1; ioctl_addr = 25'h0001000;
    @(negedge clk); ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    check("fall_wait_fetch", ioctl_wait, 1);
    @(negedge clk);
    check("fall_wait_latch", ioctl_wait, 1);
    check("fall_done_early", done, 0);
    @(negedge clk);
    check("fall_done", done, 1);
    check("fall_din", ioctl_din, 8'h77);
    check("fall_hold", cpu_hold, 0);
    check("fall_busy", busy, 0);
    @(negedge clk);
    check("fall_done_once", done, 0);
`ifdef IOCTL_UPLOAD_DIRTY_EN
    check("dirty_cleared_done", dirty, 0);
`endif

    // upload falls while idle in ACTIVE
    activate();
    do_read(25'h0, 8'h5A, 16'h7000, 10);
    @(negedge clk); ioctl_upload = 1'b0;
    check("end_hold_before", cpu_hold, 1);
    @(negedge clk);
    check("end_done", done, 1);
    check("end_hold", cpu_hold, 0);
    @(negedge clk);
    check("end_done_once", done, 0);

    // reset asserted during FETCH
    activate();
    @(negedge clk); ioctl_rd = 1'b1; ioctl_addr = 25'h0008FFF;
    @(negedge clk); ioctl_rd = 1'b0; reset = 1'b1;
    check("pre_rst_fetch", dbg_state, 3);
    @(negedge clk);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_din", ioctl_din, 8'h00);
    check("mid_rst_maddr", mem_addr, 16'h7000);
    check("mid_rst_outs", {ioctl_upload_req, ioctl_wait, cpu_hold, busy, done, timeout_err}, 0);
`ifdef IOCTL_UPLOAD_DIRTY_EN
    check("mid_rst_dirty", dirty, 0);
`endif
    reset = 1'b0; ioctl_upload = 1'b0;
    @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_state", dbg_state, 0);

`ifdef IOCTL_UPLOAD_DIRTY_EN
    // clean RAM: save_req ignored
    @(negedge clk); save_req = 1'b1;
    @(negedge clk); save_req = 1'b0;
    check("clean_no_req", ioctl_upload_req, 0);
    check("clean_idle", busy, 0);
    // write just below the window does not dirty
    @(negedge clk); cpu_we = 1'b1; cpu_addr = 16'h6FFF;
    @(negedge clk); cpu_we = 1'b0;
    check("below_win_clean", dirty, 0);
    @(negedge clk); cpu_we = 1'b1; cpu_addr = 16'h8000;
    @(negedge clk); cpu_we = 1'b0;
    check("dirty_set", dirty, 1);
    save_req = 1'b1;
    @(negedge clk); save_req = 1'b0;
    check("dirty_req", ioctl_upload_req, 1);
    ioctl_index = 8'd1; ioctl_upload = 1'b1;
    @(negedge clk);
    check("dirty_active", dbg_state, 2);
    ioctl_upload = 1'b0;
    @(negedge clk);
    check("dirty_done", done, 1);
    @(negedge clk);
    check("dirty_after_done", dirty, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ioctl_ram_upload.md
Name: ioctl_ram_upload

Overview:
- Reader side of the HPS ioctl transfer path: streams the cartridge RAM window (0x7000-0xFFFF of the 64 KB system RAM) back to the HPS on a save request.
- The download path fills this same window.
- Sits in the top level between hps_io (ioctl upload handshake) and the system RAM address/data mux.
- While an upload is active it owns the RAM read port and holds the console off the RAM.

Parameters:
- BASE_ADDR, 16'h7000, first RAM address of the uploaded window.
- LAST_ADDR, 16'hFFFF, last RAM address of the window, inclusive.
- UPLOAD_INDEX, 8'd1, ioctl_index value this block answers to.
- REQ_TIMEOUT, 24'd5000000, clk_sys cycles to wait for ioctl_upload after a request.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- save_req  in  1  one-cycle pulse to start a save
- ioctl_upload  in  1  hps_io upload-active level
- ioctl_index  in  8  hps_io transfer index
- ioctl_rd  in  1  hps_io read strobe, one cycle
- ioctl_addr  in  25  byte offset of the requested byte
- ioctl_upload_req  out  1  one-cycle request pulse to hps_io
- ioctl_din  out  8  byte returned to hps_io
- ioctl_wait  out  1  stalls hps_io until ioctl_din is valid
- mem_addr  out  16  RAM address, valid while cpu_hold=1
- mem_q  in  8  RAM read data, one-cycle latency after mem_addr
- cpu_hold  out  1  top muxes mem_addr onto RAM and blocks RAM writes
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal upload end
- timeout_err  out  1  sticky; cleared by the next save_req or by reset

Behaviour:
- Reset (synchronous): state=IDLE; every output 0 (ioctl_din=8'h00, mem_addr=BASE_ADDR). Reset asserted mid-upload aborts immediately; no done pulse.
- States: IDLE, REQUEST, ACTIVE, FETCH, LATCH.
- IDLE:
  - save_req=1 -> ioctl_upload_req=1 for exactly the next cycle, clear timeout_err, load timeout counter, go REQUEST.
  - save_req outside IDLE is ignored.
- REQUEST:
  - ioctl_upload=1 with ioctl_index==UPLOAD_INDEX -> ACTIVE.
  - Otherwise the counter decrements; on reaching 0 -> timeout_err=1, go IDLE.
  - An upload with any other index is ignored.
- ACTIVE:
  - cpu_hold=1.
  - ioctl_rd=1 -> mem_addr <= BASE_ADDR + ioctl_addr[15:0], truncated mod 2^16; go FETCH.
  - ioctl_wait is asserted combinationally in that same cycle.
- FETCH: RAM read cycle; ioctl_wait=1; go LATCH.
- LATCH:
  - ioctl_din <= mem_q, or 8'hFF when ioctl_addr[24:0] > LAST_ADDR-BASE_ADDR (out of window); go ACTIVE.
  - ioctl_wait=1 in LATCH, 0 from the following cycle.
  - Latency: rd at cycle N -> wait high N..N+2, ioctl_din valid from N+3.
- ioctl_rd while in FETCH or LATCH is ignored (protocol violation).
- ioctl_upload falling:
  - In ACTIVE: done=1 next cycle, go IDLE.
  - In FETCH or LATCH: finish the read, then done, then IDLE.
  - cpu_hold drops in the same cycle as done.
- Window size is LAST_ADDR-BASE_ADDR+1 = 36864 bytes at defaults. The last valid offset is 0x8FFF -> RAM 0xFFFF; offset 0x9000 returns 8'hFF.
- No RAM writes are ever issued by this block.

Optional Feature:
- Macro: IOCTL_UPLOAD_DIRTY_EN.
- Defined:
  - Extra inputs cpu_we (1) and cpu_addr (16); extra output dirty (1).
  - dirty sets on any cycle with cpu_we=1 and BASE_ADDR <= cpu_addr <= LAST_ADDR.
  - dirty clears on done; reset clears it.
  - A save_req arriving while dirty=0 is ignored: no request, done stays 0.
- Undefined: ports absent; every save_req in IDLE starts an upload.

Test Plan:
- Reset, then save_req -> ioctl_upload_req high one cycle exactly, busy=1; keep ioctl_upload low for REQ_TIMEOUT cycles -> timeout_err=1, state IDLE, cpu_hold never 1.
- Preload RAM[0x7000]=0x5A and RAM[0xFFFF]=0xC3; upload index 1; rd offset 0 then 0x8FFF -> ioctl_din 0x5A then 0xC3, each valid 3 cycles after rd; ioctl_wait high exactly 3 cycles per read.
- rd at offset 0x9000 -> ioctl_din=0xFF; mem_addr wraps to 0x0000; no RAM write occurs.
- ioctl_upload drops in the cycle after rd -> ioctl_din still latched, done pulses once, cpu_hold=0 the same cycle; a second save_req during ACTIVE -> no extra ioctl_upload_req.
- Assert reset while in FETCH -> next cycle all outputs 0 and state IDLE; no done pulse.
- With IOCTL_UPLOAD_DIRTY_EN: save_req with no CPU write -> ignored; cpu_we to 0x8000 -> dirty=1, save_req accepted; dirty=0 after done.
